// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline sequencing controller:
// state encoding, register-index width and nop encoding.
package hazard_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Wide enough for DRAIN_CYCLES up to 15 and LOAD_STALL_CYCLES up to 3
  localparam int SEQ_W = 4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count
);

  // count enabled events, holding once the maximum is reached
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/bubble/flush sequencing for the 5-stage pipeline: load-use
// interlock, MEM-resolved branch flush, and halt/drain/resume.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int DRAIN_CYCLES      = 4,
  parameter int CNT_W             = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             mem_pcsrc,
  input  logic             halt_req,
  input  logic             resume,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             halted,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  state_e           state_r;
  state_e           state_nxt_s;
  logic [SEQ_W-1:0] seq_cnt_r;
  logic [SEQ_W-1:0] seq_cnt_nxt_s;
  logic             rs_match_s;
  logic             rt_match_s;
  logic             hazard_s;
  logic             stall_inc_s;
  logic             flush_inc_s;

  // r0 is hard-wired, so a load targeting it can never create a dependence
  assign rs_match_s = (ex_rt == id_rs);
  assign rt_match_s = id_uses_rt && (ex_rt == id_rt);
  assign hazard_s   = ex_mem_read && (ex_rt != REG_ZERO) && (rs_match_s || rt_match_s);

  // Mealy output decode and next-state selection; taken branch dominates
  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_bubble  = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_flush  = 1'b0;
    halted        = 1'b0;
    state_nxt_s   = state_r;
    seq_cnt_nxt_s = seq_cnt_r;

    if (mem_pcsrc && (state_r != ST_HALT)) begin
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      ex_mem_flush  = 1'b1;
      state_nxt_s   = ST_RUN;
      seq_cnt_nxt_s = '0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (hazard_s) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_nxt_s   = ST_STALL;
              seq_cnt_nxt_s = SEQ_W'(LOAD_STALL_CYCLES - 1);
            end else begin
              state_nxt_s   = ST_RUN;
            end
          end else if (halt_req) begin
            pc_write      = 1'b0;
            if_id_flush   = 1'b1;
            state_nxt_s   = ST_DRAIN;
            seq_cnt_nxt_s = SEQ_W'(DRAIN_CYCLES);
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_STALL: begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
          if (seq_cnt_r <= SEQ_W'(1)) begin
            state_nxt_s   = ST_RUN;
            seq_cnt_nxt_s = '0;
          end else begin
            seq_cnt_nxt_s = seq_cnt_r - SEQ_W'(1);
          end
        end
        ST_DRAIN: begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
          if (seq_cnt_r <= SEQ_W'(1)) begin
            state_nxt_s   = ST_HALT;
            seq_cnt_nxt_s = '0;
          end else begin
            seq_cnt_nxt_s = seq_cnt_r - SEQ_W'(1);
          end
        end
        ST_HALT: begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
          halted       = 1'b1;
          if (resume) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_HALT;
          end
        end
        default: begin
          state_nxt_s   = ST_RUN;
          seq_cnt_nxt_s = '0;
        end
      endcase
    end
  end

  // sequencing state and its cycle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_RUN;
      seq_cnt_r <= '0;
    end else begin
      state_r   <= state_nxt_s;
      seq_cnt_r <= seq_cnt_nxt_s;
    end
  end

  assign state = state_r;

  // Drain bubbles are excluded: only interlock bubbles count as stalls
  assign stall_inc_s = id_ex_bubble && ((state_r == ST_RUN) || (state_r == ST_STALL));
  assign flush_inc_s = ex_mem_flush;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (stall_inc_s),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (flush_inc_s),
    .count (flush_count)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed and randomized bench for pipeline_hazard_ctrl against a
// cycle-level behavioural model of the sequencing rules.
module tb_pipeline_hazard_ctrl;

  localparam int L_CYC = 2;
  localparam int D_CYC = 4;
  localparam int CW    = 4;
  localparam int SAT   = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic [4:0]    id_rs;
  logic [4:0]    id_rt;
  logic          id_uses_rt;
  logic          ex_mem_read;
  logic [4:0]    ex_rt;
  logic          mem_pcsrc;
  logic          halt_req;
  logic          resume;
  logic          pc_write;
  logic          if_id_write;
  logic          id_ex_bubble;
  logic          if_id_flush;
  logic          id_ex_flush;
  logic          ex_mem_flush;
  logic          halted;
  logic [1:0]    state;
  logic [CW-1:0] stall_count;
  logic [CW-1:0] flush_count;

  int checks = 0;
  int errors = 0;

  // model: mode 0=RUN 1=STALL 2=DRAIN 3=HALT, left = cycles still to spend in mode
  int m_state = 0;
  int m_left  = 0;
  int m_stall = 0;
  int m_flush = 0;

  pipeline_hazard_ctrl #(
    .LOAD_STALL_CYCLES (L_CYC),
    .DRAIN_CYCLES      (D_CYC),
    .CNT_W             (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .ex_mem_read  (ex_mem_read),
    .ex_rt        (ex_rt),
    .mem_pcsrc    (mem_pcsrc),
    .halt_req     (halt_req),
    .resume       (resume),
    .pc_write     (pc_write),
    .if_id_write  (if_id_write),
    .id_ex_bubble (id_ex_bubble),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .ex_mem_flush (ex_mem_flush),
    .halted       (halted),
    .state        (state),
    .stall_count  (stall_count),
    .flush_count  (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > SAT) ? SAT : v;
  endfunction

  task automatic drive(input logic rd, input logic [4:0] ert, input logic [4:0] rs,
                       input logic [4:0] rt, input logic urt, input logic pcs,
                       input logic hr, input logic res);
    ex_mem_read = rd;
    ex_rt       = ert;
    id_rs       = rs;
    id_rt       = rt;
    id_uses_rt  = urt;
    mem_pcsrc   = pcs;
    halt_req    = hr;
    resume      = res;
  endtask

  task automatic model_reset();
    m_state = 0;
    m_left  = 0;
    m_stall = 0;
    m_flush = 0;
  endtask

  // called just after a negedge with inputs driven; returns at the next negedge
  task automatic step(input string tag);
    logic       hz;
    logic       br;
    logic       frozen;
    logic [6:0] e_ctl;
    logic [6:0] o_ctl;
    #1;
    hz = ex_mem_read && (ex_rt != 5'd0) &&
         ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    br = mem_pcsrc && (m_state != 3);
    frozen = (m_state != 0) || hz;
    e_ctl = {br || (!frozen && !halt_req),
             br || !frozen,
             !br && frozen,
             br || (!frozen && halt_req),
             br,
             br,
             m_state == 3};
    o_ctl = {pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, ex_mem_flush, halted};
    chk({tag, "_ctl"},   32'(o_ctl),       32'(e_ctl));
    chk({tag, "_state"}, 32'(state),       m_state);
    chk({tag, "_stall"}, 32'(stall_count), m_stall);
    chk({tag, "_flush"}, 32'(flush_count), m_flush);
    @(posedge clk);
    if (br) begin
      m_flush = sat(m_flush + 1);
      m_state = 0;
      m_left  = 0;
    end else begin
      case (m_state)
        0: begin
          if (hz) begin
            m_stall = sat(m_stall + 1);
            if (L_CYC > 1) begin
              m_state = 1;
              m_left  = L_CYC - 1;
            end
          end else if (halt_req) begin
            m_state = 2;
            m_left  = D_CYC;
          end
        end
        1: begin
          m_stall = sat(m_stall + 1);
          m_left--;
          if (m_left == 0) m_state = 0;
        end
        2: begin
          m_left--;
          if (m_left == 0) m_state = 3;
        end
        3: if (resume) m_state = 0;
        default: m_state = 0;
      endcase
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #12;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_pcw", 32'(pc_write), 32'd1);
    chk("rst_cnt", 32'({stall_count, flush_count}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step("idle");

    // load-use: two-cycle interlock then back to RUN
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 chk("lu_a_pcw_bub", 32'({pc_write, id_ex_bubble}), 32'b01);
    step("lu_a");
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 chk("lu_b_pcw_bub", 32'({pc_write, id_ex_bubble}), 32'b01);
    step("lu_b");
    #1 chk("lu_c_pcw_bub", 32'({pc_write, id_ex_bubble}), 32'b10);
    chk("lu_c_stallcnt", 32'(stall_count), 32'd2);
    step("lu_c");

    // no false hazards
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1 chk("nf_r0_pcw", 32'(pc_write), 32'd1);
    step("nf_r0");
    drive(1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 chk("nf_rt_bub", 32'(id_ex_bubble), 32'd0);
    step("nf_rt");

    // branch beats hazard
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    #1 chk("br_ctl", 32'({pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, ex_mem_flush}),
           32'b110111);
    step("br");
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 chk("br_flushcnt", 32'(flush_count), 32'd1);
    chk("br_state", 32'(state), 32'd0);
    step("br_after");

    // halt, drain, ignored inputs while halted, resume
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("h_req");
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < D_CYC; i++) begin
      #1 chk("h_drain_state", 32'(state), 32'd2);
      step("h_drain");
    end
    #1 chk("h_halt", 32'({state, halted}), 32'b111);
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    step("h_ign0");
    step("h_ign1");
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("h_resume");
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 chk("h_run", 32'({state, halted}), 32'b000);
    step("h_run");

    // taken branch during drain cancels the halt
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("hb_req");
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("hb_d1");
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("hb_br");
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 chk("hb_run", 32'({state, halted}), 32'b000);
    step("hb_run");

    // asynchronous reset in the middle of STALL
    drive(1'b1, 5'd9, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    step("rs_hz");
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk("rs_stall", 32'({state, pc_write, stall_count, flush_count}), 32'b001_0000_0000);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // asynchronous reset in the middle of DRAIN
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("rd_req");
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("rd_d1");
    #2 rst_n = 1'b0;
    #1 chk("rd_drain", 32'({state, pc_write, id_ex_bubble}), 32'b0010);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // stall counter saturation
    drive(1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step("sat");
    #1 chk("sat_stallcnt", 32'(stall_count), 32'd15);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("sat_end");

    // randomized traffic with small register indices so matches are frequent
    for (int i = 0; i < 1500; i++) begin
      drive(1'($urandom_range(1)), 5'($urandom_range(7)), 5'($urandom_range(7)),
            5'($urandom_range(7)), 1'($urandom_range(1)),
            1'($urandom_range(9) == 0), 1'($urandom_range(19) == 0),
            1'($urandom_range(3) == 0));
      step("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Sequencing controller for the 5-stage MIPS pipeline (fetch/decode/execute/memory/writeBack).
- Generates stall, bubble and flush controls for the PC and pipeline registers (IF_ID, ID_EX, EX_MEM).
- Handles load-use hazards, taken branches resolved in MEM, and a halt/drain/resume sequence.
- Keeps saturating performance counters for stall and flush events.

Parameters:
LOAD_STALL_CYCLES, 1, total stall cycles per load-use hazard (1..3; 1 with forwarding unit present)
DRAIN_CYCLES, 4, cycles to retire in-flight instructions before HALT (1..15)
CNT_W, 16, width of perf counters

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_rs  in  5  rs field of instruction in IF_ID
id_rt  in  5  rt field of instruction in IF_ID
id_uses_rt  in  1  IF_ID instruction reads rt (R-type, sw, beq)
ex_mem_read  in  1  MemRead bit of ID_EX M field (load in EX)
ex_rt  in  5  rt (load destination) held in ID_EX
mem_pcsrc  in  1  branch taken in MEM (Branch & zero)
halt_req  in  1  decode sees halt opcode in IF_ID
resume  in  1  restart request, sampled only in HALT
pc_write  out  1  PC register load enable
if_id_write  out  1  IF_ID load enable
id_ex_bubble  out  1  force ID_EX control fields (WB/M/EX) to zero
if_id_flush  out  1  clear IF_ID to nop
id_ex_flush  out  1  clear ID_EX controls
ex_mem_flush  out  1  clear EX_MEM controls
halted  out  1  high in HALT state
state  out  2  RUN=0, STALL=1, DRAIN=2, HALT=3
stall_count  out  CNT_W  cycles with id_ex_bubble=1, saturating
flush_count  out  CNT_W  taken-branch flush events, saturating

Behaviour:
- Reset (async, rst_n=0): state=RUN, internal counter=0, stall_count=0, flush_count=0. Outputs decode from state, so pc_write=1, if_id_write=1, all bubble/flush=0, halted=0.
- hazard = ex_mem_read & (ex_rt!=0) & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
- Outputs are combinational from state and inputs (Mealy). Zero-latency: the hazard cycle itself is stalled.
- Priority per cycle: mem_pcsrc > hazard > halt_req.
- mem_pcsrc=1 in any state except HALT:
  - if_id_flush=id_ex_flush=ex_mem_flush=1, pc_write=1 (PC loads branch target), if_id_write=1.
  - id_ex_bubble=0; hazard and halt_req are ignored.
  - next state=RUN, internal counter cleared, flush_count+1.
- RUN:
  - hazard: pc_write=0, if_id_write=0, id_ex_bubble=1. If LOAD_STALL_CYCLES>1, go to STALL with counter=LOAD_STALL_CYCLES-1; otherwise stay in RUN.
  - else halt_req: pc_write=0, if_id_flush=1 (the halt itself becomes a nop). Go to DRAIN with counter=DRAIN_CYCLES.
  - else: normal flow.
- STALL: same outputs as a hazard in RUN. Decrement counter; at counter==1 go to RUN. Inputs other than mem_pcsrc are ignored.
- DRAIN: pc_write=0, if_id_write=0, id_ex_bubble=1 (stall_count does not count these cycles). Decrement counter; at counter==1 go to HALT. A taken branch in DRAIN aborts the halt (wrong-path halt).
- HALT: pc_write=0, if_id_write=0, id_ex_bubble=1, halted=1; mem_pcsrc ignored. resume=1 → RUN next cycle. halt_req is ignored in HALT.
- stall_count increments on each cycle with id_ex_bubble=1 in RUN/STALL only. Counters hold at all-ones (saturate).
- Reset mid-STALL or mid-DRAIN returns to RUN immediately; counters are cleared.

Decomposition:
- Shared package hazard_pkg: state encoding constants (RUN/STALL/DRAIN/HALT), width of the 5-bit register-index field, nop encoding.
- One sub-module, sat_counter (CNT_W, enable, async clear), instantiated twice for the perf counters.
- The FSM and hazard compare stay in pipeline_hazard_ctrl.

Test Plan:
- Reset: drive rst_n=0 mid-cycle → state=0, pc_write=1, counters=0 without waiting for a clk edge.
- Load-use hazard: ex_mem_read=1, ex_rt=5, id_rs=5, LOAD_STALL_CYCLES=2 → pc_write=0 and id_ex_bubble=1 for exactly 2 cycles, then RUN; stall_count=2.
- No false hazard:
  - ex_rt=0 with id_rs=0 → no stall.
  - id_uses_rt=0 with ex_rt==id_rt=7 → no stall.
- Branch priority: hazard and mem_pcsrc in the same cycle → all three flushes=1, pc_write=1, id_ex_bubble=0; flush_count=1; state stays RUN.
- Halt/resume:
  - halt_req at cycle t with DRAIN_CYCLES=4 → state=DRAIN for t+1..t+4, HALT at t+5, halted=1.
  - resume=1 → RUN next cycle.
  - Repeat with mem_pcsrc at t+2 → state=RUN at t+3, no halt.
- Saturation: CNT_W=4, 20 consecutive hazard cycles → stall_count sticks at 15.
